// File: rtl/capture_ctrl.sv
// Capture controller: records samples into an external single-port RAM around a
// trigger, then streams the most recent words out newest-first over a UART handshake.
module capture_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             arm_i,
    input  logic             abort_i,
    input  logic             trg_i,
    input  logic             smpl_stb_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [15:0]      delay_cnt_i,
    input  logic [15:0]      read_cnt_i,
    output logic             we_o,
    output logic [DEPTH-1:0] addr_o,
    output logic [WIDTH-1:0] mem_o,
    input  logic [WIDTH-1:0] mem_i,
    input  logic             tx_rdy_i,
    output logic             tx_stb_o,
    output logic [31:0]      tx_o,
    input  logic             xon_i,
    input  logic             xoff_i,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TX_W    = 32;
    localparam int unsigned ENTRIES = 1 << DEPTH;
    localparam logic [DEPTH-1:0] PTR_ONE = DEPTH'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        DELAY,
        RD_ADDR,
        RD_WAIT,
        SEND
    } state_t;

    state_t           state_q, state_d;
    logic [DEPTH-1:0] wptr_q, wptr_d;
    logic [DEPTH-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [CNT_W-1:0] delay_q, delay_d;
    logic [CNT_W-1:0] read_q, read_d;
    logic [CNT_W-1:0] read_clamp;
    logic             pause_q, pause_d;
    logic [TX_W-1:0]  tx_d;
    logic             tx_stb_d;
    logic             done_d;
    logic             start_rd;

    // Next-state and datapath; the RAM port follows the current state so that
    // read data returned one cycle after RD_ADDR is ready to capture in RD_WAIT.
    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        remain_d   = remain_q;
        delay_d    = delay_q;
        read_d     = read_q;
        tx_d       = tx_o;
        tx_stb_d   = 1'b0;
        done_d     = 1'b0;
        start_rd   = 1'b0;
        we_o       = 1'b0;
        addr_o     = rptr_q;
        mem_o      = '0;
        pause_d    = xoff_i ? 1'b1 : (xon_i ? 1'b0 : pause_q);
        read_clamp = (32'(read_q) >= ENTRIES) ? CNT_W'(ENTRIES) : read_q;

        case (state_q)
            IDLE: begin
                if (arm_i) begin
                    state_d = ARMED;
                    wptr_d  = '0;
                    delay_d = delay_cnt_i;
                    read_d  = read_cnt_i;
                end
            end
            ARMED, DELAY: begin
                if (smpl_stb_i) begin
                    we_o   = 1'b1;
                    addr_o = wptr_q;
                    mem_o  = data_i;
                    wptr_d = wptr_q + PTR_ONE;
                end
                if (state_q == ARMED) begin
                    if (trg_i) begin
                        if (delay_q == '0) begin
                            start_rd = 1'b1;
                        end else begin
                            state_d  = DELAY;
                            remain_d = delay_q;
                        end
                    end
                end else if (smpl_stb_i && remain_q != '0) begin
                    remain_d = remain_q - CNT_ONE;
                    if (remain_q == CNT_ONE) begin
                        start_rd = 1'b1;
                    end
                end
            end
            RD_ADDR: begin
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                tx_d    = TX_W'(mem_i);
                state_d = SEND;
            end
            SEND: begin
                if (tx_rdy_i && !pause_q) begin
                    tx_stb_d = 1'b1;
                    rptr_d   = rptr_q - PTR_ONE;
                    remain_d = (remain_q != '0) ? remain_q - CNT_ONE : '0;
                    if (remain_q <= CNT_ONE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RD_ADDR;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Readout starts from the newest written word
        if (start_rd) begin
            rptr_d   = wptr_d - PTR_ONE;
            remain_d = read_clamp;
            if (read_clamp == '0) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = RD_ADDR;
            end
        end

        if (abort_i) begin
            state_d  = IDLE;
            we_o     = 1'b0;
            tx_stb_d = 1'b0;
            done_d   = 1'b0;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            wptr_q   <= '0;
            rptr_q   <= '0;
            remain_q <= '0;
            delay_q  <= '0;
            read_q   <= '0;
            pause_q  <= 1'b0;
            tx_o     <= '0;
            tx_stb_o <= 1'b0;
            done_o   <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            remain_q <= remain_d;
            delay_q  <= delay_d;
            read_q   <= read_d;
            pause_q  <= pause_d;
            tx_o     <= tx_d;
            tx_stb_o <= tx_stb_d;
            done_o   <= done_d;
            busy_o   <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// Randomized scoreboard bench for capture_ctrl: a queue-based capture/readout
// model predicts RAM writes and transmitted words; a monitor checks them.
module tb_capture_ctrl;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned DEPTH   = 5;
    localparam int          ENTRIES = 32;

    typedef struct packed {
        logic [DEPTH-1:0] addr;
        logic [WIDTH-1:0] data;
    } wr_t;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             arm_i;
    logic             abort_i;
    logic             trg_i;
    logic             smpl_stb_i;
    logic [WIDTH-1:0] data_i;
    logic [15:0]      delay_cnt_i;
    logic [15:0]      read_cnt_i;
    logic             we_o;
    logic [DEPTH-1:0] addr_o;
    logic [WIDTH-1:0] mem_o;
    logic [WIDTH-1:0] mem_i;
    logic             tx_rdy_i;
    logic             tx_stb_o;
    logic [31:0]      tx_o;
    logic             xon_i;
    logic             xoff_i;
    logic             busy_o;
    logic             done_o;

    capture_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i), .arm_i(arm_i), .abort_i(abort_i),
        .trg_i(trg_i), .smpl_stb_i(smpl_stb_i), .data_i(data_i),
        .delay_cnt_i(delay_cnt_i), .read_cnt_i(read_cnt_i),
        .we_o(we_o), .addr_o(addr_o), .mem_o(mem_o), .mem_i(mem_i),
        .tx_rdy_i(tx_rdy_i), .tx_stb_o(tx_stb_o), .tx_o(tx_o),
        .xon_i(xon_i), .xoff_i(xoff_i), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    // Single-port RAM, read data one cycle after the address
    logic [WIDTH-1:0] ram [ENTRIES];
    always @(posedge clk) begin
        if (we_o) ram[addr_o] <= mem_o;
        mem_i <= ram[addr_o];
    end

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    wr_t         exp_wr[$];
    logic [31:0] exp_tx[$];
    logic [31:0] got_tx[$];
    logic [WIDTH-1:0] model_mem [ENTRIES];

    int wcount, rem, cur_d, cur_r;
    bit in_delay, model_done, aborted;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write and every strobe must match the next expected item
    wr_t         mon_w;
    logic [31:0] mon_t;
    always @(negedge clk) begin
        if (we_o) begin
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got addr %0d data %0h expected none", addr_o, mem_o);
            end else begin
                mon_w = exp_wr.pop_front();
                if (mon_w.addr !== addr_o || mon_w.data !== mem_o) begin
                    errors++;
                    $display("FAIL write: got addr %0d data %0h expected addr %0d data %0h",
                             addr_o, mem_o, mon_w.addr, mon_w.data);
                end
            end
        end
        if (tx_stb_o) begin
            got_tx.push_back(tx_o);
            checks++;
            if (exp_tx.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected: got %0h expected none", tx_o);
            end else begin
                mon_t = exp_tx.pop_front();
                if (mon_t !== tx_o) begin
                    errors++;
                    $display("FAIL tx_word: got %0h expected %0h", tx_o, mon_t);
                end
            end
        end
        if (done_o) done_seen++;
    end

    // Capture complete: the newest min(R, 2^DEPTH) written words go out newest-first
    task automatic finish_model();
        int n;
        int clamp;
        n     = wcount;
        clamp = (cur_r > ENTRIES) ? ENTRIES : cur_r;
        for (int j = 0; j < clamp; j++)
            exp_tx.push_back(32'(model_mem[(n - 1 - j) & (ENTRIES - 1)]));
        model_done = 1'b1;
    endtask

    task automatic model_cycle(input bit stb, input bit trg, input logic [WIDTH-1:0] data, input bit abt);
        wr_t w;
        if (model_done || aborted) return;
        if (abt) begin
            aborted = 1'b1;
            return;
        end
        if (stb) begin
            w.addr = DEPTH'(wcount);
            w.data = data;
            exp_wr.push_back(w);
            model_mem[wcount & (ENTRIES - 1)] = data;
            wcount++;
        end
        if (!in_delay) begin
            if (trg) begin
                if (cur_d == 0) finish_model();
                else begin
                    in_delay = 1'b1;
                    rem      = cur_d;
                end
            end
        end else if (stb) begin
            rem--;
            if (rem == 0) finish_model();
        end
    endtask

    // mode: 0 normal, 1 xoff after 2nd word, 2 abort in DELAY, 3 stall in SEND
    task automatic run(input int d, input int r, input int trig_at, input int mode,
                       input bit incr_data, input bit rnd_stb);
        int k, tail, done_base, tx_base, abort_at, seen;
        bit stb, trg, abt, paused;
        logic [WIDTH-1:0] data;
        k = 0; tail = 0; paused = 0;
        abort_at  = trig_at + 5;
        done_base = done_seen;
        tx_base   = got_tx.size();
        cur_d = d; cur_r = r; wcount = 0; in_delay = 0; model_done = 0; aborted = 0;

        arm_i       = 1'b1;
        delay_cnt_i = 16'(d);
        read_cnt_i  = 16'(r);
        smpl_stb_i  = 1'($urandom);
        trg_i       = 1'($urandom);
        data_i      = WIDTH'($urandom);
        abort_i     = 1'b0;
        tx_rdy_i    = 1'b0;
        xon_i       = 1'b0;
        xoff_i      = 1'b0;
        step();
        arm_i       = 1'b0;
        delay_cnt_i = 16'($urandom);
        read_cnt_i  = 16'($urandom);
        check("busy_after_arm", 32'(busy_o), 32'd1);

        forever begin
            stb  = rnd_stb ? ($urandom_range(0, 2) != 0) : 1'b1;
            data = incr_data ? WIDTH'(k) : WIDTH'($urandom);
            trg  = (k >= trig_at);
            abt  = (mode == 2 && k == abort_at);
            smpl_stb_i = stb;
            data_i     = data;
            trg_i      = trg;
            abort_i    = abt;
            tx_rdy_i   = (mode == 3) ? 1'b0 : (mode == 1) ? 1'b1 : 1'($urandom);
            xoff_i     = (mode == 0) && ($urandom_range(0, 15) == 0);
            xon_i      = (mode == 0) && ($urandom_range(0, 3) == 0);
            arm_i      = (exp_tx.size() >= 2) && ($urandom_range(0, 7) == 0);
            model_cycle(stb, trg, data, abt);
            step();
            k++;
            arm_i = 1'b0;

            if (mode == 1 && !paused && got_tx.size() - tx_base == 2) begin
                smpl_stb_i = 1'b0;
                xoff_i     = 1'b1;
                step();
                xoff_i = 1'b0;
                seen   = got_tx.size();
                check("xoff_at_word2", 32'(seen - tx_base), 32'd2);
                repeat (20) step();
                check("xoff_holds", 32'(got_tx.size()), 32'(seen));
                xon_i = 1'b1;
                step();
                xon_i  = 1'b0;
                paused = 1'b1;
            end

            if (mode == 2 && k == abort_at + 1)
                check("busy_after_abort", 32'(busy_o), 32'd0);
            if (mode == 2 && k > abort_at + 30) break;
            if ((mode == 0 || mode == 1) && model_done && done_seen != done_base) tail++;
            if (mode == 3 && model_done) tail++;
            if (tail > 8) break;
            if (k > 4000) begin
                errors++;
                $display("FAIL timeout: got no completion expected done within 4000 cycles");
                break;
            end
        end

        smpl_stb_i = 1'b0; trg_i = 1'b0; abort_i = 1'b0;
        xoff_i = 1'b0; xon_i = 1'b0; arm_i = 1'b0;
        check("writes_drained", 32'(exp_wr.size()), 32'd0);
        if (mode == 0 || mode == 1) begin
            check("tx_drained", 32'(exp_tx.size()), 32'd0);
            check("done_once", 32'(done_seen - done_base), 32'd1);
        end else if (mode == 2) begin
            check("abort_no_tx", 32'(got_tx.size() - tx_base), 32'd0);
            check("abort_no_done", 32'(done_seen - done_base), 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},     32'(we_o),     32'd0);
        check({tag, "_addr"},   32'(addr_o),   32'd0);
        check({tag, "_mem"},    32'(mem_o),    32'd0);
        check({tag, "_tx_stb"}, 32'(tx_stb_o), 32'd0);
        check({tag, "_tx"},     tx_o,          32'd0);
        check({tag, "_done"},   32'(done_o),   32'd0);
        check({tag, "_busy"},   32'(busy_o),   32'd0);
    endtask

    initial begin
        int base;
        rst_i = 1'b1; arm_i = 1'b0; abort_i = 1'b0; trg_i = 1'b0; smpl_stb_i = 1'b0;
        data_i = '0; delay_cnt_i = '0; read_cnt_i = '0; tx_rdy_i = 1'b0;
        xon_i = 1'b0; xoff_i = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        rst_i = 1'b0;
        step();

        // 40 samples, trigger on the 40th, delay 0, read 32 (also fills the RAM)
        base = got_tx.size();
        run(0, 32, 39, 0, 1'b1, 1'b0);
        check("wrap_count", 32'(got_tx.size() - base), 32'd32);
        check("wrap_first", got_tx[base], 32'd39);
        check("wrap_last",  got_tx[base + 31], 32'd8);

        // Trigger on sample 0x03, delay 3, read 4
        base = got_tx.size();
        run(3, 4, 3, 0, 1'b1, 1'b0);
        check("basic_count", 32'(got_tx.size() - base), 32'd4);
        check("basic_w0", got_tx[base],     32'h06);
        check("basic_w1", got_tx[base + 1], 32'h05);
        check("basic_w2", got_tx[base + 2], 32'h04);
        check("basic_w3", got_tx[base + 3], 32'h03);

        // Read count above memory size is clamped
        base = got_tx.size();
        run(5, 40, 10, 0, 1'b0, 1'b1);
        check("clamp_count", 32'(got_tx.size() - base), 32'd32);

        // Flow control pause after the second word
        base = got_tx.size();
        run(4, 6, 7, 1, 1'b0, 1'b1);
        check("xoff_total", 32'(got_tx.size() - base), 32'd6);

        // Abort while counting post-trigger samples
        run(30, 8, 4, 2, 1'b0, 1'b0);

        // Zero read count: done without any strobe
        base = got_tx.size();
        run(2, 0, 6, 0, 1'b0, 1'b1);
        check("zero_read_count", 32'(got_tx.size() - base), 32'd0);

        for (int i = 0; i < 8; i++)
            run(int'($urandom_range(0, 40)), int'($urandom_range(0, 45)),
                int'($urandom_range(0, 50)), 0, 1'b0, 1'b1);

        // Reset while waiting in SEND
        run(2, 8, 3, 3, 1'b0, 1'b1);
        tx_rdy_i = 1'b1;
        rst_i    = 1'b1;
        step();
        check_all_zero("rst_send");
        rst_i = 1'b0;
        exp_tx.delete();
        base = got_tx.size();
        repeat (15) step();
        check("post_reset_no_tx", 32'(got_tx.size() - base), 32'd0);
        check("post_reset_idle",  32'(busy_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
